// File: rtl/q_8_41_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : q_8_41_pkg
//  Purpose  : Shared types and constants for the q_8_41 decimator control unit
//  Revision : 1.0 - initial release
// ============================================================================
package q_8_41_pkg;

  // Byte in, packed word out
  localparam int DATA_W = 8;
  localparam int WORD_W = 16;

  // Controller sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FILL0 = 3'd2,
    FILL1 = 3'd3,
    PACK  = 3'd4
  } state_t;

  // True in the two states that accept a byte from the handshake
  function automatic logic is_fill(input state_t s);
    return (s == FILL0) || (s == FILL1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/q_8_41_if.sv
`default_nettype none
// ============================================================================
//  Module   : q_8_41_if
//  Purpose  : Byte handshake, datapath strobes and frame status of the
//             q_8_41 controller
//  Revision : 1.0 - initial release
// ============================================================================
interface q_8_41_if;
  logic start;
  logic in_valid;
  logic in_ready;
  logic clr_P1_P0;
  logic load_P1_P0;
  logic load_R0;
  logic out_valid;
  logic busy;
  logic done;

  // Requester side: issues frames and offers bytes
  modport master (
    output start, in_valid,
    input  in_ready, clr_P1_P0, load_P1_P0, load_R0, out_valid, busy, done
  );

  // Controller side: accepts bytes and drives the datapath strobes
  modport slave (
    input  start, in_valid,
    output in_ready, clr_P1_P0, load_P1_P0, load_R0, out_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/q_8_41_controller.sv
`default_nettype none
// ============================================================================
//  Module   : q_8_41_controller
//  Purpose  : Sequences the q_8_41 packing datapath: clears P1/P0, loads two
//             bytes per word over a valid/ready handshake, then loads R0.
//             One frame of WORDS words is processed per start pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module q_8_41_controller
  import q_8_41_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  q_8_41_if.slave   bus
);

  localparam int CNT_W = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q;
  logic             done_q;

  logic w_clr;
  logic w_ready;
  logic w_load_p;
  logic w_load_r0;
  logic w_last;

  assign w_last = (cnt_q == LAST_WORD);

  // Next-state, word counter and combinational strobes from the current state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_clr     = 1'b0;
    w_load_r0 = 1'b0;
    w_ready   = is_fill(state_q);
    w_load_p  = is_fill(state_q) && bus.in_valid;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start) state_d = CLEAR;
      end
      CLEAR: begin
        w_clr   = 1'b1;
        state_d = FILL0;
      end
      FILL0: begin
        if (bus.in_valid) state_d = FILL1;
      end
      FILL1: begin
        if (bus.in_valid) state_d = PACK;
      end
      PACK: begin
        w_load_r0 = 1'b1;
        // Compare before incrementing so the counter never wraps
        if (w_last) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = FILL0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered status pulses; reset cancels pending pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= w_load_r0;
      done_q      <= w_load_r0 && w_last;
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.clr_P1_P0  = w_clr;
  assign bus.load_P1_P0 = w_load_p;
  assign bus.load_R0    = w_load_r0;
  assign bus.out_valid  = out_valid_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_q_8_41_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_q_8_41_controller
//  Purpose  : Self-checking bench for q_8_41_controller (WORDS=1 and WORDS=2)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_q_8_41_controller;
  import q_8_41_pkg::*;

  localparam int I_RDY  = 6;
  localparam int I_CLR  = 5;
  localparam int I_LDP  = 4;
  localparam int I_LDR  = 3;
  localparam int I_OV   = 2;
  localparam int I_BUSY = 1;
  localparam int I_DONE = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] data_in = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  q_8_41_if u_if1 ();
  q_8_41_if u_if2 ();

  assign u_if1.start    = start1;
  assign u_if1.in_valid = in_valid;
  assign u_if2.start    = start2;
  assign u_if2.in_valid = in_valid;

  q_8_41_controller #(.WORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(u_if1));
  q_8_41_controller #(.WORDS(2)) dut2 (.clk(clk), .rst(rst), .bus(u_if2));

  // Observed outputs, one packed vector per instance
  logic [6:0] obs [2];
  assign obs[0] = {u_if1.in_ready, u_if1.clr_P1_P0, u_if1.load_P1_P0, u_if1.load_R0,
                   u_if1.out_valid, u_if1.busy, u_if1.done};
  assign obs[1] = {u_if2.in_ready, u_if2.clr_P1_P0, u_if2.load_P1_P0, u_if2.load_R0,
                   u_if2.out_valid, u_if2.busy, u_if2.done};

  // Stand-in packing datapath driven by each controller's strobes
  logic [7:0]  p1 [2];
  logic [7:0]  p0 [2];
  logic [15:0] r0 [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (obs[i][I_CLR]) begin
        p1[i] <= 8'h00;
        p0[i] <= 8'h00;
      end else if (obs[i][I_LDP]) begin
        p1[i] <= p0[i];
        p0[i] <= data_in;
      end
      if (obs[i][I_LDR]) r0[i] <= {p1[i], p0[i]};
    end
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Frame-level model: frame active, clearing, bytes held in the current word,
  // words finished, pending status pulses, and the bytes of the current word
  bit          m_act [2];
  bit          m_clr [2];
  int          m_nb  [2];
  int          m_wd  [2];
  bit          m_ov  [2];
  bit          m_dn  [2];
  logic [7:0]  m_b0  [2];
  logic [7:0]  m_b1  [2];
  logic [15:0] m_exp [2];

  // Compare every cycle on the falling edge, then advance the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [6:0] e;
      logic       sv;
      int         w;
      w  = i + 1;
      sv = (i == 0) ? start1 : start2;
      e  = '0;
      if (rst) begin
        m_act[i] = 1'b0; m_clr[i] = 1'b0; m_nb[i] = 0; m_wd[i] = 0;
        m_ov[i]  = 1'b0; m_dn[i]  = 1'b0;
      end else begin
        e[I_RDY]  = m_act[i] && !m_clr[i] && (m_nb[i] < 2);
        e[I_CLR]  = m_act[i] && m_clr[i];
        e[I_LDP]  = e[I_RDY] && in_valid;
        e[I_LDR]  = m_act[i] && (m_nb[i] == 2);
        e[I_OV]   = m_ov[i];
        e[I_BUSY] = m_act[i];
        e[I_DONE] = m_dn[i];
      end
      check(obs[i] === e, (i == 0) ? "outputs_w1" : "outputs_w2", 32'(obs[i]), 32'(e));
      if (e[I_OV])
        check(r0[i] === m_exp[i], (i == 0) ? "r0_w1" : "r0_w2", 32'(r0[i]), 32'(m_exp[i]));
      check(!(obs[i][I_LDP] && obs[i][I_LDR]) &&
            (!obs[i][I_LDP] || (obs[i][I_RDY] && in_valid)),
            "strobe_rules", 32'(obs[i]), 32'(e));
      if (!rst) begin
        m_ov[i] = e[I_LDR];
        m_dn[i] = e[I_LDR] && (m_wd[i] + 1 == w);
        if (e[I_LDR]) m_exp[i] = {m_b0[i], m_b1[i]};
        if (!m_act[i]) begin
          if (sv) begin
            m_act[i] = 1'b1; m_clr[i] = 1'b1; m_nb[i] = 0; m_wd[i] = 0;
          end
        end else if (m_clr[i]) begin
          m_clr[i] = 1'b0;
        end else if (m_nb[i] < 2) begin
          if (in_valid) begin
            if (m_nb[i] == 0) m_b0[i] = data_in;
            else              m_b1[i] = data_in;
            m_nb[i]++;
          end
        end else begin
          m_nb[i] = 0;
          m_wd[i]++;
          if (m_wd[i] == w) m_act[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(); tick();
    check(obs[0] === 7'b0, "reset_w1", 32'(obs[0]), 32'h0);
    check(obs[1] === 7'b0, "reset_w2", 32'(obs[1]), 32'h0);
    rst = 1'b0;
    tick();

    // start -> CLEAR next cycle -> in_ready the cycle after
    start1 = 1'b1; start2 = 1'b1;
    tick();
    start1 = 1'b0; start2 = 1'b0;
    check(u_if1.clr_P1_P0 === 1'b1, "clr_after_start", 32'(u_if1.clr_P1_P0), 32'h1);
    check(u_if2.in_ready === 1'b0, "no_ready_in_clear", 32'(u_if2.in_ready), 32'h0);
    tick();
    check(u_if1.in_ready === 1'b1, "ready_two_after_start", 32'(u_if1.in_ready), 32'h1);
    check(u_if2.clr_P1_P0 === 1'b0, "clr_one_cycle", 32'(u_if2.clr_P1_P0), 32'h0);

    // First word AA55 with in_valid held
    in_valid = 1'b1; data_in = 8'hAA;
    tick();
    data_in = 8'h55;
    tick();
    in_valid = 1'b0;
    check(u_if1.load_R0 === 1'b1, "load_r0_at_n4", 32'(u_if1.load_R0), 32'h1);
    tick();
    check(r0[0] === 16'hAA55, "w1_word", 32'(r0[0]), 32'hAA55);
    check({u_if1.out_valid, u_if1.done, u_if1.busy} === 3'b110, "w1_done_busy",
          32'({u_if1.out_valid, u_if1.done, u_if1.busy}), 32'h6);
    check({u_if2.out_valid, u_if2.done} === 2'b10, "w2_first_not_done",
          32'({u_if2.out_valid, u_if2.done}), 32'h2);

    // Second word FF11 with gaps and an ignored start during FILL1
    tick(); tick();
    in_valid = 1'b1; data_in = 8'hFF;
    tick();
    in_valid = 1'b0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check(u_if2.clr_P1_P0 === 1'b0, "start_ignored_busy", 32'(u_if2.clr_P1_P0), 32'h0);
    tick(); tick();
    in_valid = 1'b1; data_in = 8'h11;
    tick();
    in_valid = 1'b0;
    tick();
    check(r0[1] === 16'hFF11, "w2_second_word", 32'(r0[1]), 32'hFF11);
    check({u_if2.out_valid, u_if2.done, u_if2.busy} === 3'b110, "w2_done_busy",
          32'({u_if2.out_valid, u_if2.done, u_if2.busy}), 32'h6);

    // start in the done cycle is accepted
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check(u_if2.clr_P1_P0 === 1'b1, "start_in_done_cycle", 32'(u_if2.clr_P1_P0), 32'h1);

    // Reset asserted during PACK
    tick();
    in_valid = 1'b1; data_in = 8'h12;
    tick();
    data_in = 8'h34;
    tick();
    in_valid = 1'b0;
    check(u_if2.load_R0 === 1'b1, "in_pack_before_rst", 32'(u_if2.load_R0), 32'h1);
    rst = 1'b1;
    #1;
    check({u_if2.load_R0, u_if2.busy} === 2'b00, "rst_drops_strobes",
          32'({u_if2.load_R0, u_if2.busy}), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check({u_if2.out_valid, u_if2.done, u_if2.busy} === 3'b000, "no_ov_after_rst",
          32'({u_if2.out_valid, u_if2.done, u_if2.busy}), 32'h0);

    // Long random run; the falling-edge model checks every cycle
    for (int k = 0; k < 600; k++) begin
      in_valid = ($urandom_range(0, 9) < 6);
      data_in  = 8'($urandom_range(0, 255));
      start1   = ($urandom_range(0, 7) == 0);
      start2   = ($urandom_range(0, 7) == 0);
      tick();
    end
    in_valid = 1'b0; start1 = 1'b0; start2 = 1'b0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
